// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO and its RAM.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int fifo_length);
    return 1 << fifo_length;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer bundle for fifo_sync; clk and rst stay outside.
interface fifo_sync_if #(
  parameter int DATO_WIDTH  = 8,
  parameter int FIFO_LENGTH = 4
);
  // Handshake: a wr_en push is taken at the edge when the FIFO is not full or a
  // pop is accepted on the same edge; an rd_en pop is taken when not empty.
  // Rejected requests only raise the sticky overflow/underflow flags.
  // dato qualifies datout: high exactly when datout carries a valid word.
  logic                   flush;
  logic                   err_clr;
  logic                   wr_en;
  logic [DATO_WIDTH-1:0]  datin;
  logic                   rd_en;
  logic [DATO_WIDTH-1:0]  datout;
  logic                   dato;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [FIFO_LENGTH:0]   count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output flush, err_clr, wr_en, datin, rd_en,
    input  datout, dato, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, err_clr, wr_en, datin, rd_en,
    output datout, dato, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ram.sv
// Storage array: synchronous write, asynchronous read (distributed-RAM friendly).
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with level flags, sticky errors, flush and optional FWFT read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATO_WIDTH  = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int AF_THRESH   = fifo_depth(FIFO_LENGTH) - 2,
  parameter int AE_THRESH   = 1,
  parameter int FWFT        = FIFO_STD
) (
  input  logic       clk,
  input  logic       rst,
  fifo_sync_if.slave bus
);

  localparam int DEPTH = fifo_depth(FIFO_LENGTH);
  localparam logic [FIFO_LENGTH:0] DEPTH_C = (FIFO_LENGTH + 1)'(DEPTH);
  localparam logic [FIFO_LENGTH:0] AF_C    = (FIFO_LENGTH + 1)'(AF_THRESH);
  localparam logic [FIFO_LENGTH:0] AE_C    = (FIFO_LENGTH + 1)'(AE_THRESH);

  logic [FIFO_LENGTH-1:0] wptr;
  logic [FIFO_LENGTH-1:0] rptr;
  logic [FIFO_LENGTH:0]   cnt;
  logic [DATO_WIDTH-1:0]  rdata;
  logic [DATO_WIDTH-1:0]  dout_q;
  logic                   dato_q;
  logic                   ovf_q;
  logic                   udf_q;
  logic                   full_c;
  logic                   empty_c;
  logic                   rd_accept;
  logic                   wr_accept;
  logic                   ovf_set;
  logic                   udf_set;

  assign full_c  = (cnt == DEPTH_C);
  assign empty_c = (cnt == '0);

  // Flush swallows any request in its cycle, including the error it would raise.
  assign rd_accept = bus.rd_en & ~empty_c & ~bus.flush;
  assign wr_accept = bus.wr_en & (~full_c | rd_accept) & ~bus.flush;
  assign ovf_set   = bus.wr_en & full_c & ~rd_accept & ~bus.flush;
  assign udf_set   = bus.rd_en & empty_c & ~bus.flush;

  fifo_sync_ram #(
    .WIDTH (DATO_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept & ~rst),
    .waddr (wptr),
    .wdata (bus.datin),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      dout_q <= '0;
      dato_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        dout_q <= '0;
        dato_q <= 1'b0;
      end else begin
        if (wr_accept) wptr <= wptr + 1'b1;
        if (rd_accept) begin
          rptr   <= rptr + 1'b1;
          dout_q <= rdata;
        end
        dato_q <= rd_accept;
        case ({wr_accept, rd_accept})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
      // A new error in the same cycle as err_clr leaves the flag set.
      if (bus.err_clr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign bus.datout       = (FWFT == FIFO_FWFT) ? (empty_c ? '0 : rdata) : dout_q;
  assign bus.dato         = (FWFT == FIFO_FWFT) ? ~empty_c : dato_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Single-clock, parametrised FIFO that replaces the dual-strobe FIFO in the wishbone peripherals. It buffers DATO_WIDTH-bit words between a producer and a consumer, both on one clock. Both sides use wr_en/rd_en handshakes. It adds level reporting, programmable almost-full/almost-empty flags, sticky overflow/underflow errors, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATO_WIDTH, 8, data word width in bits (>=1)
FIFO_LENGTH, 4, log2 of depth; DEPTH = 2**FIFO_LENGTH (FIFO_LENGTH >= 1)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of contents, pointers and count
err_clr  in  1  clears overflow/underflow sticky flags
wr_en  in  1  write request
datin  in  DATO_WIDTH  write data
rd_en  in  1  read request (pop)
datout  out  DATO_WIDTH  read data
dato  out  1  datout holds a valid word this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  FIFO_LENGTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not popped same cycle
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at edge): wptr=rptr=0, count=0, datout=0, dato=0, overflow=0, underflow=0. Outputs then read empty=1, full=0, almost_full=0, almost_empty=1. rst has priority over every other input. Memory contents are not cleared.
- Flush (rst=0, flush=1): same as reset for wptr, rptr, count, datout and dato. overflow/underflow are held. Any wr_en/rd_en in the same cycle is ignored.
- Pointers are FIFO_LENGTH bits wide and wrap naturally at DEPTH. count is FIFO_LENGTH+1 bits wide.
- Accepted write: wr_en & (~full | rd_accept). The write stores datin at mem[wptr] and increments wptr.
- Accepted read (rd_accept): rd_en & ~empty. It increments rptr.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with wr_en & rd_en: both are accepted and count stays DEPTH.
- Empty with wr_en & rd_en: the write is accepted, the read is rejected and underflow is set. There is no bypass and count becomes 1.
- Standard mode (FWFT=0): on an accepted read, datout <= mem[rptr] at that edge, and dato=1 for the following cycle only. Otherwise datout holds its value and dato=0.
- FWFT mode (FWFT=1): datout = mem[rptr] whenever ~empty, and dato = ~empty. rd_en acknowledges the current word. A word written into an empty FIFO appears on datout the cycle after the write edge.
- overflow is set on wr_en & full & ~rd_accept. underflow is set on rd_en & empty. Both stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, set wins.
- Status flags full, empty, almost_full, almost_empty are decoded combinationally from the registered count, so they are glitch-free relative to clk.

Decomposition:
- Shared package fifo_pkg holds the clog2 helper, DEPTH derivation, and mode constants FIFO_STD=0 and FIFO_FWFT=1.
- One sub-module, fifo_sync_ram: a DATO_WIDTH x DEPTH memory with a synchronous write port and an asynchronous read port, so it can map to distributed RAM.
- Pointer, count, flag and mode logic live in fifo_sync.

Test Plan:
1. DATO_WIDTH=8, FIFO_LENGTH=3, FWFT=0: write 0x11..0x88 over 8 cycles -> full=1, count=8, almost_full=1 from count 6. A 9th write -> overflow=1 and count stays 8.
2. From full, pop 8 times -> datout sequence 0x11..0x88, each with dato=1 one cycle after rd_en. Then empty=1. A further rd_en -> underflow=1 and datout holds 0x88.
3. Full FIFO with wr_en=rd_en=1 for 4 cycles, writing 0xA0..0xA3 -> count stays 8. A subsequent drain yields 0x55..0x88 then 0xA0..0xA3, which checks pointer wrap.
4. FWFT=1, empty: write 0x3C -> next cycle datout=0x3C and dato=1 with no rd_en. Pulse rd_en -> empty=1 and dato=0 the following cycle.
5. Count 5 with overflow=1: assert flush -> count=0, empty=1, overflow still 1. Assert err_clr -> overflow=0.
6. Assert rst mid-stream while wr_en=rd_en=1 -> next cycle all outputs are at reset values. Write 0x7E after reset -> read returns 0x7E, so no stale data is returned.
